cr16_datapath_sequencer: RTL and testbench

Programmable micro-op sequencer that drives the CR16 register-file/ALU datapath in place of a hard-coded test FSM. A small program memory holds datapath micro-ops. On start, the block fetches and issues them one at a time, producing opcode, read-port selects, one-hot register write enable and preload immediate. It captures ALU flags after every write and stops on a HALT micro-op or at end of memory. It sits between board-level start/step controls and the datapath, and its write-enable/immediate outputs also feed the 7-segment debug path.

---
 rtl/cr16_pkg.sv | 33 +++
 rtl/cr16_seq_rom.sv | 35 +++
 rtl/cr16_datapath_sequencer.sv | 130 +++++++++++++
 tb/tb_cr16_datapath_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16 micro-op sequencer: state encoding and micro-op field layout.
package cr16_pkg;

  localparam int unsigned UOP_W   = 30;
  localparam int unsigned REG_N   = 16;
  localparam int unsigned FLAG_W  = 5;

  localparam int unsigned UOP_HALT    = 29;
  localparam int unsigned UOP_USE_IMM = 28;
  localparam int unsigned UOP_OP_MSB  = 27;
  localparam int unsigned UOP_OP_LSB  = 24;
  localparam int unsigned UOP_DST_MSB = 23;
  localparam int unsigned UOP_DST_LSB = 20;
  localparam int unsigned UOP_SRA_MSB = 19;
  localparam int unsigned UOP_SRA_LSB = 16;
  localparam int unsigned UOP_IMM_MSB = 15;
  localparam int unsigned UOP_SRB_MSB = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WRITE = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // One-hot register write enable for a destination index.
  function automatic logic [REG_N-1:0] dst_onehot(input logic [3:0] dst);
    return REG_N'(1) << dst;
  endfunction

endpackage

// File: rtl/cr16_seq_rom.sv
// Micro-op program store: simple dual-port RAM, one write port and one registered read port.
module cr16_seq_rom
  import cr16_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [UOP_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [UOP_W-1:0] rdata_o
);

  logic [UOP_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register doubles as the issued micro-op; cleared by reset, contents are not.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/cr16_datapath_sequencer.sv
// Programmable micro-op sequencer driving the CR16 register-file/ALU datapath.
module cr16_datapath_sequencer
  import cr16_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                I_CLK,
  input  logic                I_NRESET,
  input  logic                I_ENABLE,
  input  logic                I_START,
  input  logic                I_STEP_MODE,
  input  logic                I_STEP,
  input  logic                I_PROG_WE,
  input  logic [AW-1:0]       I_PROG_ADDR,
  input  logic [UOP_W-1:0]    I_PROG_DATA,
  input  logic [FLAG_W-1:0]   I_FLAGS,
  output logic [3:0]          O_OPCODE,
  output logic [3:0]          O_READ_PORT_A_SEL,
  output logic [3:0]          O_READ_PORT_B_SEL,
  output logic [REG_N-1:0]    O_REG_ENABLE,
  output logic [15:0]         O_PRELOAD_IMM,
  output logic                O_IMM_SEL,
  output logic [FLAG_W-1:0]   O_FLAGS_LATCHED,
  output logic [AW-1:0]       O_PC,
  output logic                O_BUSY,
  output logic                O_DONE
);

  state_e              state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  logic [REG_N-1:0]    reg_en_q, reg_en_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [UOP_W-1:0]    uop;
  logic                rom_we, rom_re, last_op, use_imm;

  assign rom_we = I_ENABLE && I_PROG_WE && !busy_q;
  assign rom_re = I_ENABLE && (state_q == ST_FETCH);

  cr16_seq_rom #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rom (
    .clk_i   (I_CLK),
    .rst_ni  (I_NRESET),
    .we_i    (rom_we),
    .waddr_i (I_PROG_ADDR),
    .wdata_i (I_PROG_DATA),
    .re_i    (rom_re),
    .raddr_i (pc_q),
    .rdata_o (uop)
  );

  // End of memory terminates exactly like an explicit HALT.
  assign last_op = uop[UOP_HALT] || (pc_q == AW'(DEPTH - 1));
  assign use_imm = uop[UOP_USE_IMM];

  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      state_q <= ST_IDLE;
    end else if (I_ENABLE) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (I_START) state_d = ST_FETCH;
      ST_FETCH:         state_d = ST_ISSUE;
      ST_ISSUE:         state_d = ST_WRITE;
      ST_WRITE: begin
        if (last_op)          state_d = ST_DONE;
        else if (I_STEP_MODE) state_d = ST_PAUSE;
        else                  state_d = ST_FETCH;
      end
      ST_PAUSE:         if (I_STEP) state_d = ST_FETCH;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    reg_en_d = '0;
    flags_d  = flags_q;
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d   = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE, ST_DONE: if (I_START) pc_d = '0;
      ST_ISSUE:         reg_en_d = dst_onehot(uop[UOP_DST_MSB:UOP_DST_LSB]);
      ST_WRITE: begin
        flags_d = I_FLAGS;
        if (state_d == ST_FETCH) pc_d = pc_q + AW'(1);
      end
      ST_PAUSE:         if (I_STEP) pc_d = pc_q + AW'(1);
      default:          ;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      pc_q     <= '0;
      reg_en_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (I_ENABLE) begin
      pc_q     <= pc_d;
      reg_en_q <= reg_en_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // A stalled WRITE keeps its pulse pending but must not reach the register file.
  assign O_REG_ENABLE      = I_ENABLE ? reg_en_q : '0;
  assign O_OPCODE          = uop[UOP_OP_MSB:UOP_OP_LSB];
  assign O_READ_PORT_A_SEL = uop[UOP_SRA_MSB:UOP_SRA_LSB];
  assign O_READ_PORT_B_SEL = use_imm ? 4'h0 : uop[UOP_SRB_MSB:0];
  assign O_PRELOAD_IMM     = use_imm ? uop[UOP_IMM_MSB:0] : 16'h0000;
  assign O_IMM_SEL         = use_imm;
  assign O_FLAGS_LATCHED   = flags_q;
  assign O_PC              = pc_q;
  assign O_BUSY            = busy_q;
  assign O_DONE            = done_q;

endmodule

// File: tb/tb_cr16_datapath_sequencer.sv
// Directed bench for cr16_datapath_sequencer: per-cycle vector table plus multi-cycle corner sequences.
module tb_cr16_datapath_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          I_CLK, I_NRESET, I_ENABLE, I_START, I_STEP_MODE, I_STEP, I_PROG_WE;
  logic [AW-1:0] I_PROG_ADDR;
  logic [29:0]   I_PROG_DATA;
  logic [4:0]    I_FLAGS;
  logic [3:0]    O_OPCODE, O_READ_PORT_A_SEL, O_READ_PORT_B_SEL;
  logic [15:0]   O_REG_ENABLE, O_PRELOAD_IMM;
  logic          O_IMM_SEL, O_BUSY, O_DONE;
  logic [4:0]    O_FLAGS_LATCHED;
  logic [AW-1:0] O_PC;

  cr16_datapath_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_ENABLE(I_ENABLE), .I_START(I_START),
    .I_STEP_MODE(I_STEP_MODE), .I_STEP(I_STEP), .I_PROG_WE(I_PROG_WE),
    .I_PROG_ADDR(I_PROG_ADDR), .I_PROG_DATA(I_PROG_DATA), .I_FLAGS(I_FLAGS),
    .O_OPCODE(O_OPCODE), .O_READ_PORT_A_SEL(O_READ_PORT_A_SEL),
    .O_READ_PORT_B_SEL(O_READ_PORT_B_SEL), .O_REG_ENABLE(O_REG_ENABLE),
    .O_PRELOAD_IMM(O_PRELOAD_IMM), .O_IMM_SEL(O_IMM_SEL),
    .O_FLAGS_LATCHED(O_FLAGS_LATCHED), .O_PC(O_PC), .O_BUSY(O_BUSY), .O_DONE(O_DONE)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [4:0]  flags_in;
    logic [15:0] en;
    logic [1:0]  pc;
    logic        busy;
    logic        done;
    logic        isel;
    logic [3:0]  op;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] imm;
    logic [4:0]  fl;
  } vec_t;

  vec_t        tbl [10];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  int          dcyc;
  logic [15:0] wq [$];
  int          cq [$];

  function automatic logic [29:0] mk(input logic halt, input logic ui, input logic [3:0] op,
                                     input logic [3:0] dst, input logic [3:0] sa,
                                     input logic [15:0] imm);
    return {halt, ui, op, dst, sa, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle, land on the falling edge and log any register write seen.
  task automatic tick();
    @(posedge I_CLK);
    @(negedge I_CLK);
    cyc++;
    if (O_REG_ENABLE != 16'h0000) begin
      wq.push_back(O_REG_ENABLE);
      cq.push_back(cyc);
    end
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [29:0] data);
    I_PROG_WE = 1'b1; I_PROG_ADDR = addr; I_PROG_DATA = data;
    tick();
    I_PROG_WE = 1'b0;
  endtask

  task automatic load_p1();
    load(2'd0, mk(1'b0, 1'b1, 4'h0, 4'd1, 4'd0, 16'h0005));
    load(2'd1, mk(1'b0, 1'b1, 4'h0, 4'd2, 4'd0, 16'h0003));
    load(2'd2, mk(1'b1, 1'b0, 4'h1, 4'd3, 4'd1, 16'h0002));
  endtask

  task automatic start();
    wq.delete(); cq.delete();
    cyc = 0;
    I_START = 1'b1;
    tick();
    I_START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int done_cycle);
    int n = 0;
    while (!O_DONE && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", 32'(O_DONE), 32'd1);
    done_cycle = O_DONE ? cyc : -1;
  endtask

  task automatic chk_p1_writes(input string tag, input int c0);
    chk({tag, "_nwr"}, 32'(wq.size()), 32'd3);
    if (wq.size() == 3) begin
      chk({tag, "_wr0"}, 32'(wq[0]), 32'h0002); chk({tag, "_cy0"}, 32'(cq[0]), 32'(c0));
      chk({tag, "_wr1"}, 32'(wq[1]), 32'h0004); chk({tag, "_cy1"}, 32'(cq[1]), 32'(c0 + 3));
      chk({tag, "_wr2"}, 32'(wq[2]), 32'h0008); chk({tag, "_cy2"}, 32'(cq[2]), 32'(c0 + 6));
    end
  endtask

  task automatic step_expect(input logic [15:0] exp_en, input logic [1:0] exp_pc, input logic stray);
    I_STEP = 1'b1;
    tick();
    I_STEP = 1'b0;
    chk("step_fetch_pc", 32'(O_PC), 32'(exp_pc));
    tick();
    I_STEP = stray;
    tick();
    I_STEP = 1'b0;
    chk("step_write_en", 32'(O_REG_ENABLE), 32'(exp_en));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    I_NRESET = 1'b0; I_ENABLE = 1'b1; I_START = 1'b0; I_STEP_MODE = 1'b0; I_STEP = 1'b0;
    I_PROG_WE = 1'b0; I_PROG_ADDR = '0; I_PROG_DATA = '0; I_FLAGS = '0;
    cyc = 0;

    tbl[0] = '{5'b00001, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 5'b00000};
    tbl[1] = '{5'b00010, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0005, 5'b00000};
    tbl[2] = '{5'b10101, 16'h0002, 2'd0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0005, 5'b00000};
    tbl[3] = '{5'b00100, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0005, 5'b10101};
    tbl[4] = '{5'b00011, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0003, 5'b10101};
    tbl[5] = '{5'b01010, 16'h0004, 2'd1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0003, 5'b10101};
    tbl[6] = '{5'b00110, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0003, 5'b01010};
    tbl[7] = '{5'b00111, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b0, 4'h1, 4'h1, 4'h2, 16'h0000, 5'b01010};
    tbl[8] = '{5'b11111, 16'h0008, 2'd2, 1'b1, 1'b0, 1'b0, 4'h1, 4'h1, 4'h2, 16'h0000, 5'b01010};
    tbl[9] = '{5'b00000, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b0, 4'h1, 4'h1, 4'h2, 16'h0000, 5'b11111};

    repeat (3) tick();
    I_NRESET = 1'b1;
    chk("rst_busy", 32'(O_BUSY), 32'd0);
    chk("rst_done", 32'(O_DONE), 32'd0);
    chk("rst_pc", 32'(O_PC), 32'd0);
    chk("rst_en", 32'(O_REG_ENABLE), 32'd0);
    chk("rst_op", 32'(O_OPCODE), 32'd0);
    chk("rst_imm", 32'(O_PRELOAD_IMM), 32'd0);
    chk("rst_flags", 32'(O_FLAGS_LATCHED), 32'd0);

    // Three-op program, checked cycle by cycle from the start edge.
    load_p1();
    load(2'd3, mk(1'b0, 1'b1, 4'h0, 4'd7, 4'd0, 16'h7777));
    start();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("v%0d_en", i + 1), 32'(O_REG_ENABLE), 32'(tbl[i].en));
      chk($sformatf("v%0d_pc", i + 1), 32'(O_PC), 32'(tbl[i].pc));
      chk($sformatf("v%0d_busy", i + 1), 32'(O_BUSY), 32'(tbl[i].busy));
      chk($sformatf("v%0d_done", i + 1), 32'(O_DONE), 32'(tbl[i].done));
      chk($sformatf("v%0d_isel", i + 1), 32'(O_IMM_SEL), 32'(tbl[i].isel));
      chk($sformatf("v%0d_op", i + 1), 32'(O_OPCODE), 32'(tbl[i].op));
      chk($sformatf("v%0d_a", i + 1), 32'(O_READ_PORT_A_SEL), 32'(tbl[i].a));
      chk($sformatf("v%0d_b", i + 1), 32'(O_READ_PORT_B_SEL), 32'(tbl[i].b));
      chk($sformatf("v%0d_imm", i + 1), 32'(O_PRELOAD_IMM), 32'(tbl[i].imm));
      chk($sformatf("v%0d_flags", i + 1), 32'(O_FLAGS_LATCHED), 32'(tbl[i].fl));
      I_FLAGS = tbl[i].flags_in;
      if (i < 9) tick();
    end
    I_FLAGS = '0;

    // No HALT anywhere: run to the last address and stop there.
    for (int i = 0; i < 4; i++) load(AW'(i), mk(1'b0, 1'b1, 4'h0, 4'(4 + i), 4'd0, 16'(i + 1)));
    start();
    chk("eom_pc_restart", 32'(O_PC), 32'd0);
    wait_done(40, dcyc);
    chk("eom_done_cyc", 32'(dcyc), 32'd13);
    chk("eom_pc", 32'(O_PC), 32'd3);
    repeat (5) tick();
    chk("eom_pc_hold", 32'(O_PC), 32'd3);
    chk("eom_done_hold", 32'(O_DONE), 32'd1);
    chk("eom_nwr", 32'(wq.size()), 32'd4);
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      chk($sformatf("eom_wr%0d", i), 32'(wq[i]), 32'(16'h0010 << i));
      chk($sformatf("eom_cy%0d", i), 32'(cq[i]), 32'(3 + 3 * i));
    end

    // Step mode: one write per I_STEP, stray I_STEP during ISSUE ignored.
    load_p1();
    I_STEP_MODE = 1'b1;
    start();
    repeat (7) tick();
    chk("step_first_nwr", 32'(wq.size()), 32'd1);
    chk("step_pause_pc", 32'(O_PC), 32'd0);
    chk("step_pause_busy", 32'(O_BUSY), 32'd1);
    step_expect(16'h0004, 2'd1, 1'b1);
    repeat (4) tick();
    chk("step_second_nwr", 32'(wq.size()), 32'd2);
    chk("step_pause2_pc", 32'(O_PC), 32'd1);
    step_expect(16'h0008, 2'd2, 1'b0);
    tick();
    chk("step_done", 32'(O_DONE), 32'd1);
    chk("step_total_nwr", 32'(wq.size()), 32'd3);
    I_STEP_MODE = 1'b0;

    // Five stalled cycles in ISSUE; a START while busy must be ignored.
    start();
    tick();
    I_ENABLE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_en", 32'(O_REG_ENABLE), 32'd0);
      chk("stall_imm_hold", 32'(O_PRELOAD_IMM), 32'h0005);
    end
    I_ENABLE = 1'b1;
    tick();
    tick();
    I_START = 1'b1;
    tick();
    I_START = 1'b0;
    wait_done(40, dcyc);
    chk_p1_writes("stall", 8);
    chk("stall_done_cyc", 32'(dcyc), 32'd15);

    // Reset during WRITE, then rerun while trying to overwrite address 1.
    start();
    tick();
    tick();
    chk("rw_en_before", 32'(O_REG_ENABLE), 32'h0002);
    I_FLAGS = 5'b10101;
    I_NRESET = 1'b0;
    tick();
    I_NRESET = 1'b1;
    I_FLAGS = '0;
    chk("rw_en", 32'(O_REG_ENABLE), 32'd0);
    chk("rw_pc", 32'(O_PC), 32'd0);
    chk("rw_busy", 32'(O_BUSY), 32'd0);
    chk("rw_imm", 32'(O_PRELOAD_IMM), 32'd0);
    chk("rw_isel", 32'(O_IMM_SEL), 32'd0);
    chk("rw_flags", 32'(O_FLAGS_LATCHED), 32'd0);
    repeat (3) tick();
    chk("rw_no_more_wr", 32'(wq.size()), 32'd1);
    start();
    I_PROG_WE = 1'b1; I_PROG_ADDR = 2'd1; I_PROG_DATA = mk(1'b0, 1'b1, 4'h0, 4'd15, 4'd0, 16'hBEEF);
    repeat (6) tick();
    I_PROG_WE = 1'b0;
    wait_done(40, dcyc);
    chk_p1_writes("restart", 3);
    chk("restart_done_cyc", 32'(dcyc), 32'd10);
    start();
    wait_done(40, dcyc);
    chk_p1_writes("rerun", 3);

    // START and program write together in IDLE: FETCH sees the new word at 0.
    I_NRESET = 1'b0;
    tick();
    I_NRESET = 1'b1;
    I_PROG_WE = 1'b1; I_PROG_ADDR = 2'd0; I_PROG_DATA = mk(1'b1, 1'b1, 4'h2, 4'd9, 4'd0, 16'h00AA);
    wq.delete(); cq.delete();
    cyc = 0;
    I_START = 1'b1;
    tick();
    I_START = 1'b0; I_PROG_WE = 1'b0;
    tick();
    chk("sim_imm", 32'(O_PRELOAD_IMM), 32'h00AA);
    chk("sim_op", 32'(O_OPCODE), 32'h2);
    wait_done(20, dcyc);
    chk("sim_done_cyc", 32'(dcyc), 32'd4);
    chk("sim_pc", 32'(O_PC), 32'd0);
    chk("sim_nwr", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) chk("sim_wr", 32'(wq[0]), 32'h0200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
